// File: rtl/queue_uart_pkg.sv
// Shared definitions for the queue-fed UART transmitter.
// Contents: FSM state enumeration, UART frame geometry, bytes per queue word.
package queue_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  localparam int FRAME_BITS     = 10;              // start + 8 data + stop
  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = FRAME_BITS - 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last cycle of a bit.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   restart - holds the counter at 0 (asserted while outside a frame)
//   tick    - high on the final clk cycle of the current bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/queue_uart_tx.sv
// Pops 32-bit words from an upstream queue and serializes them on a UART
// line, most significant byte first, each byte framed 8N1 LSB first.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   enable    - permits starting a new word
//   q_empty   - upstream queue empty flag (only looked at in IDLE)
//   q_data    - upstream read data, valid POP_LAT edges after q_pop
//   q_pop     - one-cycle pop request
//   tx        - serial line, idle high
//   busy      - high whenever the FSM is not in IDLE
//   word_done - one-cycle pulse after the last stop bit of a word
//
// state | meaning
// IDLE  | line high, waiting for enable and a non-empty queue
// POP   | q_pop asserted for this single cycle
// WAIT  | waiting out the queue read latency, then latch q_data
// START | start bit (tx=0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (tx=1); next byte or end of word
module queue_uart_tx
  import queue_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int POP_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        q_empty,
  input  logic [31:0] q_data,
  output logic        q_pop,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WORD - 1);
  // WAIT lasts POP_LAT-1 cycles; unused when POP_LAT < 2
  localparam logic [7:0] WAIT_LAST = 8'(POP_LAT - 2);

  state_t      state, state_next;
  logic [2:0]  bit_idx, bit_next;
  logic [1:0]  byte_idx, byte_next;
  logic [31:0] shift_word, word_next;
  logic [7:0]  wait_cnt, wait_next;
  logic [7:0]  cur_byte;
  logic        tx_next;
  logic        done_next;
  logic        rst_done;
  logic        baud_tick;
  logic        baud_restart;

  // Counter runs only inside a frame; every in-frame state change happens on
  // a tick, where the counter wraps to 0 anyway, so each bit starts at 0.
  assign baud_restart = !(state == ST_START || state == ST_DATA || state == ST_STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (baud_tick)
  );

  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    word_next  = shift_word;
    wait_next  = wait_cnt;
    done_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        // rst_done keeps the first pop off the first edge after reset release
        if (enable && !q_empty && rst_done) begin
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        wait_next = '0;
        if (POP_LAT < 2) begin
          state_next = ST_START;
          word_next  = q_data;
          byte_next  = '0;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = ST_START;
          word_next  = q_data;
          byte_next  = '0;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx == BIT_LAST) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (byte_idx == BYTE_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_START;
            byte_next  = byte_idx + 2'd1;
            word_next  = {shift_word[23:0], 8'h00};
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered outputs line
    // up with the state register instead of trailing it by a cycle.
    cur_byte = word_next[31:24];
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = cur_byte[bit_next];
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift_word <= '0;
      wait_cnt   <= '0;
      rst_done   <= 1'b0;
      tx         <= 1'b1;
      q_pop      <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_idx    <= bit_next;
      byte_idx   <= byte_next;
      shift_word <= word_next;
      wait_cnt   <= wait_next;
      rst_done   <= 1'b1;
      tx         <= tx_next;
      q_pop      <= (state_next == ST_POP);
      busy       <= (state_next != ST_IDLE);
      word_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_queue_uart_tx.sv
// Scoreboard bench for queue_uart_tx: directed words are queued in a simple
// upstream queue model, expected bytes are pushed into exp_q, and a UART
// receiver process decodes tx and compares each byte as it arrives.
module tb_queue_uart_tx;

  localparam int CPB = 4;
  localparam int PL  = 2;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        enable  = 1'b0;
  logic        q_empty = 1'b1;
  logic [31:0] q_data  = 32'h0;
  logic        q_pop;
  logic        tx;
  logic        busy;
  logic        word_done;

  queue_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .POP_LAT     (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_pop     (q_pop),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem[$];
  logic [7:0]  exp_q[$];
  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // One negedge step; also plays the upstream queue (data driven on the
  // pop cycle, well ahead of the POP_LAT-th edge).
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (q_pop === 1'b1) begin
      pop_cnt++;
      if (mem.size() > 0) q_data = mem.pop_front();
    end
    q_empty = (mem.size() == 0);
    if (word_done === 1'b1) done_cnt++;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_it);
    mem.push_back(w);
    q_empty = 1'b0;
    if (expect_it) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    end
  endtask

  task automatic wait_tx_low(input string name);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) timeout(name);
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 2000) begin
      tick();
      n++;
    end
    if (done_cnt == base) timeout(name);
  endtask

  // UART receiver / scoreboard checker
  initial begin : rx_monitor
    logic [9:0] frame;
    logic       aborted;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      aborted = 1'b0;
      frame   = '1;
      for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
        @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (c % CPB == CPB/2) frame[c/CPB] = tx;
      end
      if (!aborted) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rx_byte: got unexpected byte %02h, want none", frame[8:1]);
        end else begin
          want = exp_q.pop_front();
          if (frame[8:1] !== want || frame[0] !== 1'b0 || frame[9] !== 1'b1) begin
            n_err++;
            $display("FAIL rx_byte: got %02h start=%b stop=%b, want %02h start=0 stop=1",
                     frame[8:1], frame[0], frame[9], want);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c0;
    int p0;
    int g;
    int bad;

    // reset state
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_q_pop", 32'(q_pop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);
    rst = 1'b0;
    tick();

    // single word, timing and pop count
    p0 = pop_cnt;
    push_word(32'h12345678, 1'b1);
    enable = 1'b1;
    wait_tx_low("t1_start");
    c0 = cyc;
    wait_done("t1_done");
    check("t1_word_len", 32'(cyc - c0), 32'd160);
    check("t1_pops", 32'(pop_cnt - p0), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // empty queue with enable high
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (q_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t2_empty_idle_bad_cycles", 32'(bad), 32'd0);

    // back-to-back words and the inter-word gap
    enable = 1'b0;
    p0 = pop_cnt;
    push_word(32'hA5A5A5A5, 1'b1);
    push_word(32'h0000FFFF, 1'b1);
    enable = 1'b1;
    wait_tx_low("t3_start");
    wait_done("t3_done1");
    g = 0;
    while (tx === 1'b1 && g < 50) begin
      g++;
      tick();
    end
    check("t3_gap", 32'(g), 32'(1 + PL));
    wait_done("t3_done2");
    check("t3_pops", 32'(pop_cnt - p0), 32'd2);

    // reset during DATA of byte 2
    push_word(32'hDEADBEEF, 1'b1);
    wait_tx_low("t4_start");
    repeat (50) tick();
    rst = 1'b1;
    #1;
    check("t4_rst_tx", 32'(tx), 32'd1);
    check("t4_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    exp_q.delete();
    push_word(32'h3C817EC3, 1'b1);
    rst = 1'b0;
    tick();
    check("t4_no_pop_first_edge", 32'(q_pop), 32'd0);
    wait_done("t4_done");

    // enable dropped mid-word
    enable = 1'b0;
    tick();
    p0 = pop_cnt;
    push_word(32'h0F1E2D3C, 1'b1);
    push_word(32'h9C4E27D1, 1'b0);
    enable = 1'b1;
    wait_tx_low("t5_start");
    repeat (10) tick();
    enable = 1'b0;
    wait_done("t5_done");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (q_pop !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t5_idle_bad_cycles", 32'(bad), 32'd0);
    check("t5_pops", 32'(pop_cnt - p0), 32'd1);

    // q_data disturbed after capture
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] w;
      w = 32'h9C4E27D1;
      exp_q.push_back(w[i*8 +: 8]);
    end
    enable = 1'b1;
    wait_tx_low("t6_start");
    q_data = 32'h63B1D82E;
    repeat (60) tick();
    q_data = 32'h00000000;
    wait_done("t6_done");

    repeat (50) tick();
    check("end_exp_q_left", 32'(exp_q.size()), 32'd0);
    check("end_total_pops", 32'(pop_cnt), 32'd7);
    check("end_total_words", 32'(done_cnt), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
